// File: rtl/led_pattern_sequencer.sv
// Autonomous LED pattern sequencer: walks a host-programmed pattern table and
// writes each entry to the LED PIO over an Avalon-MM master at a programmable interval.
module led_pattern_sequencer #(
    parameter int NUM_PATTERNS = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            avs_address,
    input  logic                  avs_chipselect,
    input  logic                  avs_write_n,
    input  logic [31:0]           avs_writedata,
    output logic [31:0]           avs_readdata,
    output logic [1:0]            avm_address,
    output logic                  avm_write,
    output logic [DATA_WIDTH-1:0] avm_writedata,
    input  logic                  avm_waitrequest,
    output logic                  busy
);

    localparam int IDX_W = $clog2(NUM_PATTERNS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic                  en_q, en_d;
    logic                  oneshot_q, oneshot_d;
    logic [CNT_WIDTH-1:0]  period_q, period_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [31:0]           wcount_q, wcount_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  avm_write_q, avm_write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] pattern_q [NUM_PATTERNS];

    logic             host_we;
    logic             ctrl_we;
    logic             period_we;
    logic             pat_sel;
    logic             pat_we;
    logic [IDX_W-1:0] pat_idx;

    assign host_we   = avs_chipselect && !avs_write_n;
    assign ctrl_we   = host_we && (avs_address == 4'd0);
    assign period_we = host_we && (avs_address == 4'd1);
    // Pattern window starts at word 8; offsets beyond the table depth are unmapped.
    assign pat_sel   = avs_address[3] && ((avs_address[2:0] >> IDX_W) == 3'd0);
    assign pat_we    = host_we && pat_sel;
    assign pat_idx   = avs_address[IDX_W-1:0];

    assign avm_address   = 2'b00;
    assign avm_write     = avm_write_q;
    assign avm_writedata = wdata_q;
    assign busy          = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= '{default: '0};
        end else if (pat_we) begin
            pattern_q[pat_idx] <= avs_writedata[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        avs_readdata = '0;
        case (avs_address)
            4'd0: avs_readdata[1:0] = {oneshot_q, en_q};
            4'd1: avs_readdata[CNT_WIDTH-1:0] = period_q;
            4'd2: begin
                avs_readdata[0]          = busy;
                avs_readdata[4 +: IDX_W] = idx_q;
            end
            4'd3: avs_readdata = wcount_q;
            default: begin
                if (pat_sel) begin
                    avs_readdata[DATA_WIDTH-1:0] = pattern_q[pat_idx];
                end
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        oneshot_d   = oneshot_q;
        period_d    = period_q;
        cnt_d       = cnt_q;
        wcount_d    = wcount_q;
        idx_d       = idx_q;
        avm_write_d = avm_write_q;
        wdata_d     = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (en_q) begin
                    state_d     = S_WRITE;
                    avm_write_d = 1'b1;
                    wdata_d     = pattern_q[idx_q];
                end
            end
            S_WRITE: begin
                if (!avm_waitrequest) begin
                    avm_write_d = 1'b0;
                    wcount_d    = wcount_q + 32'd1;
                    cnt_d       = period_q;
                    if (oneshot_q && (idx_q == IDX_W'(NUM_PATTERNS - 1))) begin
                        en_d    = 1'b0;
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else if (!en_q) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d     = S_WRITE;
                    avm_write_d = 1'b1;
                    wdata_d     = pattern_q[idx_q];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Host CTRL writes override the sequencer: clearing EN always rewinds idx,
        // and setting EN while already running leaves the sequence untouched.
        if (ctrl_we) begin
            oneshot_d = avs_writedata[1];
            if (!avs_writedata[0]) begin
                en_d  = 1'b0;
                idx_d = '0;
            end else if (!en_q) begin
                en_d = 1'b1;
            end
        end
        if (period_we) begin
            period_d = avs_writedata[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            en_q        <= 1'b0;
            oneshot_q   <= 1'b0;
            period_q    <= '0;
            cnt_q       <= '0;
            wcount_q    <= '0;
            idx_q       <= '0;
            avm_write_q <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            oneshot_q   <= oneshot_d;
            period_q    <= period_d;
            cnt_q       <= cnt_d;
            wcount_q    <= wcount_d;
            idx_q       <= idx_d;
            avm_write_q <= avm_write_d;
            wdata_q     <= wdata_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: register-access vector table plus directed
// multi-cycle sequences against hand-computed expectations.
module tb_led_pattern_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  avs_address;
    logic        avs_chipselect;
    logic        avs_write_n;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [1:0]  avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    led_pattern_sequencer #(
        .NUM_PATTERNS(4),
        .DATA_WIDTH  (32),
        .CNT_WIDTH   (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .avs_address    (avs_address),
        .avs_chipselect (avs_chipselect),
        .avs_write_n    (avs_write_n),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Accepted-transfer monitor, sampled mid-cycle.
    logic [31:0] acc_q[$];
    int          acc_cyc[$];
    int          cyc  = 0;
    int          n_hi = 0;

    always @(negedge clk) begin
        cyc++;
        if (avm_write) n_hi++;
        if (avm_write && !avm_waitrequest) begin
            acc_q.push_back(avm_writedata);
            acc_cyc.push_back(cyc);
        end
    end

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [31:0] d);
        avs_address    = a;
        avs_writedata  = d;
        avs_chipselect = 1'b1;
        avs_write_n    = 1'b0;
        tick();
        avs_chipselect = 1'b0;
        avs_write_n    = 1'b1;
    endtask

    task automatic host_read(input string name, input logic [3:0] a, input logic [31:0] exp);
        avs_address = a;
        #1;
        check(name, avs_readdata, exp);
    endtask

    task automatic wait_writes(input string name, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (acc_q.size() >= n) break;
            tick();
        end
        check(name, acc_q.size(), n);
    endtask

    task automatic wait_avm_write(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (avm_write) break;
            tick();
        end
        check(name, {31'b0, avm_write}, 32'd1);
    endtask

    task automatic clear_mon();
        acc_q.delete();
        acc_cyc.delete();
        n_hi = 0;
    endtask

    initial begin
        int stable;

        tbl[0]  = '{1'b0, 4'd0,  32'h0,        32'h0};
        tbl[1]  = '{1'b0, 4'd1,  32'h0,        32'h0};
        tbl[2]  = '{1'b0, 4'd2,  32'h0,        32'h0};
        tbl[3]  = '{1'b0, 4'd3,  32'h0,        32'h0};
        tbl[4]  = '{1'b0, 4'd8,  32'h0,        32'h0};
        tbl[5]  = '{1'b0, 4'd11, 32'h0,        32'h0};
        tbl[6]  = '{1'b1, 4'd8,  32'h1,        32'h0};
        tbl[7]  = '{1'b1, 4'd9,  32'h2,        32'h0};
        tbl[8]  = '{1'b1, 4'd10, 32'h4,        32'h0};
        tbl[9]  = '{1'b1, 4'd11, 32'h8,        32'h0};
        tbl[10] = '{1'b1, 4'd4,  32'hDEAD,     32'h0};
        tbl[11] = '{1'b1, 4'd12, 32'h55,       32'h0};
        tbl[12] = '{1'b1, 4'd2,  32'hFF,       32'h0};
        tbl[13] = '{1'b1, 4'd3,  32'h1234,     32'h0};
        tbl[14] = '{1'b1, 4'd1,  32'h3,        32'h0};
        tbl[15] = '{1'b0, 4'd8,  32'h0,        32'h1};
        tbl[16] = '{1'b0, 4'd9,  32'h0,        32'h2};
        tbl[17] = '{1'b0, 4'd10, 32'h0,        32'h4};
        tbl[18] = '{1'b0, 4'd11, 32'h0,        32'h8};
        tbl[19] = '{1'b0, 4'd4,  32'h0,        32'h0};
        tbl[20] = '{1'b0, 4'd12, 32'h0,        32'h0};
        tbl[21] = '{1'b0, 4'd2,  32'h0,        32'h0};
        tbl[22] = '{1'b0, 4'd3,  32'h0,        32'h0};
        tbl[23] = '{1'b0, 4'd1,  32'h0,        32'h3};

        reset           = 1'b1;
        avs_address     = '0;
        avs_chipselect  = 1'b0;
        avs_write_n     = 1'b1;
        avs_writedata   = '0;
        avm_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_avm_write", {31'b0, avm_write}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_avm_wdata", avm_writedata, 32'd0);
        check("rst_avm_addr", {30'b0, avm_address}, 32'd0);

        foreach (tbl[i]) begin
            if (tbl[i].wr) host_write(tbl[i].addr, tbl[i].wdata);
            else host_read($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
        end

        // Free-running, PERIOD=3: writes every 5 cycles.
        clear_mon();
        host_write(4'd0, 32'h1);
        wait_writes("runA_count", 5, 60);
        host_read("runA_wcount", 4'd3, 32'd5);
        check("runA_hi_cycles", n_hi, 5);
        check("runA_d0", acc_q[0], 32'h1);
        check("runA_d1", acc_q[1], 32'h2);
        check("runA_d2", acc_q[2], 32'h4);
        check("runA_d3", acc_q[3], 32'h8);
        check("runA_d4", acc_q[4], 32'h1);
        for (int i = 0; i < 4; i++)
            check($sformatf("runA_gap%0d", i), acc_cyc[i+1] - acc_cyc[i], 32'd5);
        host_write(4'd0, 32'h0);
        repeat (2) tick();
        check("runA_stop_busy", {31'b0, busy}, 32'd0);

        // Second write stalled for 4 cycles.
        clear_mon();
        host_write(4'd0, 32'h1);
        wait_writes("runB_first", 1, 20);
        avm_waitrequest = 1'b1;
        wait_avm_write("runB_req", 20);
        stable = 0;
        for (int i = 0; i < 4; i++) begin
            if (avm_write && avm_writedata == 32'h2) stable++;
            tick();
        end
        avm_waitrequest = 1'b0;
        if (avm_write && avm_writedata == 32'h2) stable++;
        tick();
        check("runB_stable", stable, 5);
        check("runB_drop", {31'b0, avm_write}, 32'd0);
        check("runB_accepts", acc_q.size(), 2);
        host_read("runB_wcount", 4'd3, 32'd7);
        host_write(4'd0, 32'h0);

        // One-shot, PERIOD=0.
        clear_mon();
        host_write(4'd1, 32'h0);
        host_write(4'd0, 32'h3);
        wait_writes("runC_count", 4, 30);
        repeat (10) tick();
        check("runC_total", acc_q.size(), 4);
        check("runC_d0", acc_q[0], 32'h1);
        check("runC_d3", acc_q[3], 32'h8);
        for (int i = 0; i < 3; i++)
            check($sformatf("runC_gap%0d", i), acc_cyc[i+1] - acc_cyc[i], 32'd2);
        host_read("runC_ctrl", 4'd0, 32'h2);
        host_read("runC_status", 4'd2, 32'h0);
        check("runC_busy", {31'b0, busy}, 32'd0);
        host_read("runC_wcount", 4'd3, 32'd11);

        // Clear EN while the second write is stalled.
        clear_mon();
        host_write(4'd1, 32'h3);
        host_write(4'd0, 32'h1);
        wait_writes("runD_first", 1, 20);
        avm_waitrequest = 1'b1;
        wait_avm_write("runD_req", 20);
        repeat (2) tick();
        host_write(4'd0, 32'h0);
        check("runD_held", {31'b0, avm_write}, 32'd1);
        check("runD_hdata", avm_writedata, 32'h2);
        avm_waitrequest = 1'b0;
        tick();
        check("runD_busy", {31'b0, busy}, 32'd0);
        host_read("runD_status", 4'd2, 32'h0);
        check("runD_accepts", acc_q.size(), 2);
        check("runD_data", acc_q[1], 32'h2);
        host_read("runD_wcount", 4'd3, 32'd13);
        repeat (15) tick();
        check("runD_quiet", acc_q.size(), 2);

        // Overwrite PATTERN[0] while it is in flight.
        clear_mon();
        host_write(4'd1, 32'h0);
        avm_waitrequest = 1'b1;
        host_write(4'd0, 32'h1);
        wait_avm_write("runE_req", 10);
        check("runE_inflight", avm_writedata, 32'h1);
        host_write(4'd8, 32'hAA);
        check("runE_latched", avm_writedata, 32'h1);
        avm_waitrequest = 1'b0;
        wait_writes("runE_count", 5, 40);
        check("runE_d0", acc_q[0], 32'h1);
        check("runE_d4", acc_q[4], 32'hAA);
        host_write(4'd0, 32'h0);
        repeat (2) tick();

        // Reset while a write is stalled.
        avm_waitrequest = 1'b1;
        host_write(4'd0, 32'h1);
        wait_avm_write("runF_req", 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        check("runF_avm_write", {31'b0, avm_write}, 32'd0);
        check("runF_busy", {31'b0, busy}, 32'd0);
        host_read("runF_ctrl", 4'd0, 32'h0);
        host_read("runF_wcount", 4'd3, 32'h0);
        host_read("runF_pat0", 4'd8, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
